// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Gives the UART TX FIFO write port to one of two byte-stream producers for a
// whole message, so the bytes of two messages never interleave.
//   requester 0 : PS/2 keyboard translator
//   requester 1 : terminal report generator
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   inValid[1:0]      requester i presents a byte
//   inData[15:0]      byte of requester i in bits [8i+7:8i]
//   inLast[1:0]       presented byte closes the message
//   inReady[1:0]      byte of requester i is accepted this cycle
//   fifoFull          FIFO cannot take a byte this cycle
//   fifoWriteRequest  FIFO write strobe (combinational)
//   fifoInData        byte written, 0 when not writing
//   grantValid        a requester holds the grant
//   grantId           index of the granted requester
//   abortPulse        one-cycle pulse when a stalled grant is revoked
//
// state | meaning
// ------+--------------------------------------------
// IDLE  | no grant; arbitrate among valid requesters
// BUSY  | grant held by grant_q until last byte or stall timeout
module uart_tx_arbiter #(
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_WIDTH     = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  inValid,
  input  logic [15:0] inData,
  input  logic [1:0]  inLast,
  output logic [1:0]  inReady,
  input  logic        fifoFull,
  output logic        fifoWriteRequest,
  output logic [7:0]  fifoInData,
  output logic        grantValid,
  output logic        grantId,
  output logic        abortPulse
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // The timeout fires on the stall cycle that brings the count to
  // STALL_TIMEOUT-1, i.e. when the registered count is STALL_TIMEOUT-2.
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(STALL_TIMEOUT - 2);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 prio_q, prio_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 abort_q, abort_d;

  logic       req_valid;
  logic       req_last;
  logic [7:0] req_byte;
  logic       transfer;
  logic       stall_tick;
  logic       timeout;

  always_comb begin
    req_valid  = inValid[grant_q];
    req_last   = inLast[grant_q];
    req_byte   = grant_q ? inData[15:8] : inData[7:0];

    state_d    = state_q;
    grant_d    = grant_q;
    prio_d     = prio_q;
    cnt_d      = cnt_q;
    abort_d    = 1'b0;
    inReady    = 2'b00;
    transfer   = 1'b0;
    stall_tick = 1'b0;
    timeout    = 1'b0;

    case (state_q)
      IDLE: begin
        if (|inValid) begin
          state_d = BUSY;
          cnt_d   = '0;
          // Both valid: pointer decides; otherwise the single valid one.
          grant_d = (&inValid) ? prio_q : inValid[1];
        end
      end
      BUSY: begin
        inReady[grant_q] = !fifoFull;
        transfer         = req_valid && !fifoFull;
        // Backpressured cycles are not the requester's fault and do not count.
        stall_tick       = !req_valid && !fifoFull;
        timeout          = stall_tick && (cnt_q == CNT_LIMIT);
        if (transfer) begin
          cnt_d = '0;
          if (req_last) begin
            state_d = IDLE;
            prio_d  = ~grant_q;
          end
        end else if (timeout) begin
          state_d = IDLE;
          prio_d  = ~grant_q;
          abort_d = 1'b1;
          cnt_d   = '0;
        end else if (stall_tick && (cnt_q != '1)) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Nothing is accepted or written while reset is asserted, even if the
    // registers still say BUSY before the reset edge.
    if (rst) begin
      inReady  = 2'b00;
      transfer = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  assign fifoWriteRequest = transfer;
  assign fifoInData       = transfer ? req_byte : 8'h00;
  assign grantValid       = (state_q == BUSY) && !rst;
  assign grantId          = grant_q && !rst;
  assign abortPulse       = abort_q && !rst;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (STALL_TIMEOUT=8).
// Directed messages are loaded into per-requester beat queues; the expected
// FIFO byte stream (byte, granted id, cycle) is pushed when a test starts and
// a negedge monitor pops one entry per FIFO write.
module tb_uart_tx_arbiter;

  localparam int TO = 8;

  typedef struct packed {
    logic       id;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  inValid = 2'b00;
  logic [15:0] inData = 16'h0000;
  logic [1:0]  inLast = 2'b00;
  logic [1:0]  inReady;
  logic        fifoFull = 1'b0;
  logic        fifoWriteRequest;
  logic [7:0]  fifoInData;
  logic        grantValid;
  logic        grantId;
  logic        abortPulse;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   base = 0;
  exp_t exp_q[$];
  logic [8:0] beats0[$];
  logic [8:0] beats1[$];
  logic acc0 = 1'b0;
  logic acc1 = 1'b0;

  uart_tx_arbiter #(.STALL_TIMEOUT(TO), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inData(inData), .inLast(inLast),
    .inReady(inReady), .fifoFull(fifoFull), .fifoWriteRequest(fifoWriteRequest),
    .fifoInData(fifoInData), .grantValid(grantValid), .grantId(grantId),
    .abortPulse(abortPulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
    end
  endtask

  task automatic expect_byte(input logic id, input logic [7:0] data, input int c);
    exp_t e;
    e.id = id;
    e.data = data;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Requester driver: retire an accepted beat, then present the next one.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (acc0) void'(beats0.pop_front());
      if (acc1) void'(beats1.pop_front());
      if (beats0.size() > 0) begin
        inValid[0] = 1'b1; inData[7:0] = beats0[0][7:0]; inLast[0] = beats0[0][8];
      end else begin
        inValid[0] = 1'b0; inData[7:0] = 8'h00; inLast[0] = 1'b0;
      end
      if (beats1.size() > 0) begin
        inValid[1] = 1'b1; inData[15:8] = beats1[0][7:0]; inLast[1] = beats1[0][8];
      end else begin
        inValid[1] = 1'b0; inData[15:8] = 8'h00; inLast[1] = 1'b0;
      end
    end
  end

  // Monitor: every FIFO write must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      acc0 = inValid[0] & inReady[0];
      acc1 = inValid[1] & inReady[1];
      if (fifoWriteRequest) begin
        check("write_while_full", int'(fifoFull), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", int'(fifoInData), -1);
        end else begin
          e = exp_q.pop_front();
          check("write_data", int'(fifoInData), int'(e.data));
          check("write_id", int'(grantId), int'(e.id));
          check("write_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic goto_pos(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic goto_neg(input int k);
    do @(negedge clk); while (cyc < k);
  endtask

  task automatic sync();
    @(posedge clk);
    #2;
    base = cyc;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || beats0.size() != 0 || beats1.size() != 0 || grantValid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(n < 200), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, including the cycle rst is high.
    goto_neg(1);
    check("rst_inReady", int'(inReady), 0);
    check("rst_write", int'(fifoWriteRequest), 0);
    check("rst_fifoInData", int'(fifoInData), 0);
    check("rst_grantValid", int'(grantValid), 0);
    check("rst_grantId", int'(grantId), 0);
    check("rst_abort", int'(abortPulse), 0);
    goto_pos(2);
    rst = 1'b0;
    goto_neg(2);
    check("post_rst_grantValid", int'(grantValid), 0);

    // Basic keyboard message.
    sync();
    beats0.push_back({1'b0, 8'h1B});
    beats0.push_back({1'b0, 8'h5B});
    beats0.push_back({1'b1, 8'h41});
    expect_byte(1'b0, 8'h1B, base + 2);
    expect_byte(1'b0, 8'h5B, base + 3);
    expect_byte(1'b0, 8'h41, base + 4);
    goto_neg(base + 1);
    check("basic_no_grant_yet", int'(grantValid), 0);
    goto_neg(base + 4);
    check("basic_grant_held", int'(grantValid), 1);
    goto_neg(base + 5);
    check("basic_grant_released", int'(grantValid), 0);
    wait_idle("basic_drain");

    // Contention right after reset: pointer 0 picks requester 0.
    sync();
    rst = 1'b1;
    goto_pos(base + 1);
    rst = 1'b0;
    sync();
    beats0.push_back({1'b0, 8'h1B});
    beats0.push_back({1'b0, 8'h5B});
    beats0.push_back({1'b1, 8'h42});
    beats1.push_back({1'b0, 8'h1B});
    beats1.push_back({1'b0, 8'h5B});
    beats1.push_back({1'b0, 8'h32});
    beats1.push_back({1'b0, 8'h34});
    beats1.push_back({1'b0, 8'h3B});
    beats1.push_back({1'b0, 8'h38});
    beats1.push_back({1'b0, 8'h30});
    beats1.push_back({1'b1, 8'h52});
    expect_byte(1'b0, 8'h1B, base + 2);
    expect_byte(1'b0, 8'h5B, base + 3);
    expect_byte(1'b0, 8'h42, base + 4);
    expect_byte(1'b1, 8'h1B, base + 6);
    expect_byte(1'b1, 8'h5B, base + 7);
    expect_byte(1'b1, 8'h32, base + 8);
    expect_byte(1'b1, 8'h34, base + 9);
    expect_byte(1'b1, 8'h3B, base + 10);
    expect_byte(1'b1, 8'h38, base + 11);
    expect_byte(1'b1, 8'h30, base + 12);
    expect_byte(1'b1, 8'h52, base + 13);
    goto_neg(base + 3);
    check("contend_other_held", int'(inReady[1]), 0);
    wait_idle("contend_drain");

    // Round-robin with continuous single-byte messages (pointer is 0 here).
    sync();
    for (int k = 0; k < 3; k++) begin
      beats0.push_back({1'b1, 8'h30 + 8'(k)});
      beats1.push_back({1'b1, 8'h40 + 8'(k)});
      expect_byte(1'b0, 8'h30 + 8'(k), base + 2 + 4 * k);
      expect_byte(1'b1, 8'h40 + 8'(k), base + 4 + 4 * k);
    end
    wait_idle("rr_drain");

    // Backpressure for 5 cycles after byte 5B.
    sync();
    beats0.push_back({1'b0, 8'h1B});
    beats0.push_back({1'b0, 8'h5B});
    beats0.push_back({1'b1, 8'h41});
    expect_byte(1'b0, 8'h1B, base + 2);
    expect_byte(1'b0, 8'h5B, base + 3);
    expect_byte(1'b0, 8'h41, base + 9);
    goto_pos(base + 4);
    fifoFull = 1'b1;
    for (int k = 4; k <= 8; k++) begin
      goto_neg(base + k);
      check("bp_inReady", int'(inReady), 0);
      check("bp_no_write", int'(fifoWriteRequest), 0);
    end
    goto_pos(base + 9);
    fifoFull = 1'b0;
    wait_idle("bp_drain");

    // Stall timeout: pointer is 1, so requester 1 wins, stalls after 1B.
    sync();
    beats1.push_back({1'b0, 8'h1B});
    beats0.push_back({1'b1, 8'h61});
    expect_byte(1'b1, 8'h1B, base + 2);
    expect_byte(1'b0, 8'h61, base + 11);
    goto_neg(base + 5);
    check("stall_req0_held", int'(inReady[0]), 0);
    goto_neg(base + 9);
    check("to_abort_early", int'(abortPulse), 0);
    goto_neg(base + 10);
    check("to_abort", int'(abortPulse), 1);
    check("to_grant_dropped", int'(grantValid), 0);
    goto_neg(base + 11);
    check("to_abort_one_cycle", int'(abortPulse), 0);
    check("to_regrant", int'(grantValid), 1);
    wait_idle("to_drain");

    // Stall timeout with fifoFull during the stall: those cycles don't count.
    sync();
    beats1.push_back({1'b0, 8'h1B});
    expect_byte(1'b1, 8'h1B, base + 2);
    goto_pos(base + 4);
    fifoFull = 1'b1;
    goto_pos(base + 7);
    fifoFull = 1'b0;
    goto_neg(base + 12);
    check("to_full_abort_early", int'(abortPulse), 0);
    goto_neg(base + 13);
    check("to_full_abort", int'(abortPulse), 1);
    wait_idle("to_full_drain");

    // Reset in the middle of requester 1's message while the pointer is 1.
    sync();
    beats0.push_back({1'b1, 8'h70});
    beats1.push_back({1'b0, 8'hA1});
    beats1.push_back({1'b0, 8'hA2});
    beats1.push_back({1'b1, 8'hA3});
    expect_byte(1'b0, 8'h70, base + 2);
    expect_byte(1'b1, 8'hA1, base + 4);
    expect_byte(1'b0, 8'h71, base + 7);
    expect_byte(1'b1, 8'hA2, base + 9);
    expect_byte(1'b1, 8'hA3, base + 10);
    goto_pos(base + 5);
    rst = 1'b1;
    beats0.push_back({1'b1, 8'h71});
    goto_neg(base + 5);
    check("mid_rst_no_write", int'(fifoWriteRequest), 0);
    check("mid_rst_inReady", int'(inReady), 0);
    check("mid_rst_grantValid", int'(grantValid), 0);
    goto_pos(base + 6);
    rst = 1'b0;
    goto_neg(base + 6);
    check("after_rst_grantValid", int'(grantValid), 0);
    check("after_rst_write", int'(fifoWriteRequest), 0);
    wait_idle("rst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit FIFO write port between two byte-stream producers: requester 0, the PS/2 keyboard translator, and requester 1, the terminal report generator (cursor-position and device-status replies). Each producer sends multi-byte messages such as escape sequences. The arbiter grants the FIFO to one producer for a whole message, so bytes from the two sources never interleave. It sits between the producers and the UART TX FIFO, applies FIFO-full backpressure, and releases a requester that stalls mid-message.

## Interface
- STALL_TIMEOUT, 1024: cycles a granted requester may hold `inValid` low mid-message before its grant is revoked; legal range ≥2.
- CNT_WIDTH, 11: width of the stall counter; must satisfy 2^CNT_WIDTH > STALL_TIMEOUT.

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- inValid  in  2  bit i: requester i presents a byte
- inData  in  16  byte of requester i in bits [8i+7:8i]
- inLast  in  2  bit i: presented byte is the final byte of the message
- inReady  out  2  bit i: byte of requester i is accepted this cycle when inValid[i] is also high
- fifoFull  in  1  UART TX FIFO full
- fifoWriteRequest  out  1  write strobe to the FIFO
- fifoInData  out  8  byte written to the FIFO
- grantValid  out  1  a requester currently holds the grant (state BUSY)
- grantId  out  1  index of the granted requester
- abortPulse  out  1  one-cycle pulse when a grant is revoked by stall timeout

## Operation
- States:
  - IDLE: no grant.
  - BUSY: grant held by `grantId`.
- Reset (the cycle rst is high and the one after):
  - state IDLE, grantId 0, priority pointer 0, stall counter 0.
  - inReady 0, fifoWriteRequest 0, fifoInData 0, grantValid 0, abortPulse 0.
- IDLE → BUSY: taken when any inValid bit is high.
  - One valid requester: it is granted.
  - Both valid: the requester named by the priority pointer wins.
- BUSY outputs:
  - `inReady[grantId] = !fifoFull`; the other inReady bit is 0.
  - transfer = `inValid[grantId] & inReady[grantId]`.
  - fifoWriteRequest = transfer, combinational.
  - fifoInData = granted byte when fifoWriteRequest is 1, else 0.
- Transfer with `inLast[grantId]` high → IDLE; priority pointer ← `~grantId` (round-robin).
- Stall counter (BUSY only):
  - Clears on every transfer and on entry to BUSY.
  - Increments on cycles with `inValid[grantId]` low.
  - Cycles with fifoFull high do not increment it.
  - Saturates; never wraps.
- Stall timeout: when the counter reaches STALL_TIMEOUT-1 and inValid is still low:
  - next state IDLE, abortPulse high for one cycle;
  - priority pointer ← `~grantId`.
  - Bytes already written stay in the FIFO.
- The non-granted requester is held (inReady 0) for as long as the grant lasts, regardless of its inValid.
- Single-byte message (inValid and inLast high on the first beat) is legal.
- The FIFO is never written when fifoFull is high; no byte is duplicated or dropped.

## Timing
- Grant latency: inValid rises in IDLE at cycle t → grantValid=1 at t+1; the first byte can be written at t+1.
- Throughput inside a message: one byte per cycle while fifoFull is low.
- After the last byte is written at cycle t:
  - IDLE at t+1, and a new grant is decided at t+1;
  - the next write is no earlier than t+2 (one bubble cycle between messages).
- fifoFull asserted at cycle t blocks the write in cycle t combinationally; the byte is held and writes when fifoFull falls.
- Timeout: the last stall cycle is counted at cycle t → abortPulse at t+1 with grantValid 0; a new grant is possible at t+2.
- Reset mid-message: state forced IDLE at the next edge. No fifoWriteRequest in any cycle with rst high, even if BUSY before the edge.
- Requester rules:
  - Once inValid is high, inData and inLast must stay stable until accepted.
  - A requester may drop inValid between bytes; those cycles count toward the stall timeout.

## Test plan
- Basic keyboard message: requester 0 only sends 1B 5B 41 (last on 41), fifoFull=0 → grant at t+1; FIFO writes 1B,5B,41 on t+1..t+3; grantValid falls at t+4.
- Contention after reset: both requesters valid at the same cycle. Requester 0 sends 1B 5B 42; requester 1 sends 1B 5B 32 34 3B 38 30 52 (ESC[24;80R). Required FIFO order: 1B 5B 42, then the full 8-byte reply. No interleaving, one bubble cycle between messages.
- Round-robin: both requesters hold single-byte messages continuously. Writes alternate 1,0,1,0 after an initial 0, with one write every two cycles.
- Backpressure: fifoFull high for 5 cycles mid-message after byte 5B. No write during those cycles, inReady[grantId]=0, stall counter stays at 0. Byte 41 is written in the first cycle fifoFull is low.
- Stall timeout (STALL_TIMEOUT=8): requester 1 sends 1B then drops inValid. abortPulse rises exactly 8 cycles after the 1B write, grantValid falls. A pending single-byte message 61 from requester 0 is then granted and written.
- Reset mid-message: rst during byte 2 of 3. No write in the reset cycle; IDLE and grantValid 0 after it; the next request re-arbitrates with pointer 0.
